// File: rtl/fpadd_wb.sv
// Registered writeback stage behind the fpadd datapath: 2-entry skid buffer, NaN-boxing, sticky fflags.
// Latency: 1 cycle from accept to out_valid when the stage is empty, or when it holds one entry that retires that same cycle.
// Backpressure: in_ready comes straight from the state register; once out_ready drops, at most one more entry is taken.
//
// Ports:
//   clk, reset                       clock, async active-high reset
//   in_valid/in_ready                upstream handshake; in_result/in_flags/in_denorm/in_p/in_tag payload
//   out_valid/out_ready              downstream handshake; out_result/out_flags/out_denorm/out_tag payload
//   fflags, fflags_wr/_wdata/_clr    accrued exception flags and software access
module fpadd_wb #(
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [63:0]      in_result,
    input  logic [4:0]       in_flags,
    input  logic             in_denorm,
    input  logic             in_p,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [63:0]      out_result,
    output logic [4:0]       out_flags,
    output logic             out_denorm,
    output logic [TAG_W-1:0] out_tag,
    output logic [4:0]       fflags,
    input  logic             fflags_wr,
    input  logic [4:0]       fflags_wdata,
    input  logic             fflags_clr
);

    typedef struct packed {
        logic [63:0]      result;
        logic [4:0]       flags;
        logic             denorm;
        logic [TAG_W-1:0] tag;
    } entry_t;

    typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

    state_t state, state_nxt;
    entry_t main_q, skid_q, cap;
    logic   accept, retire;
    logic   load_main_in, load_main_skid, load_skid;
    logic [4:0] retire_flags;

    // NaN-boxing is done on the way in so both registers hold final values.
    always_comb begin
        cap.result = in_p ? {32'hFFFF_FFFF, in_result[31:0]} : in_result;
        cap.flags  = in_flags;
        cap.denorm = in_denorm;
        cap.tag    = in_tag;
    end

    assign in_ready  = (state != FULL);
    assign out_valid = (state != EMPTY);
    assign accept    = in_valid && in_ready;
    assign retire    = out_valid && out_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= EMPTY;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt      = state;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        case (state)
            EMPTY: begin
                if (accept) begin
                    load_main_in = 1'b1;
                    state_nxt    = ONE;
                end
            end
            ONE: begin
                if (accept && retire) begin
                    // Main drains and refills in the same edge.
                    load_main_in = 1'b1;
                end else if (accept) begin
                    load_skid = 1'b1;
                    state_nxt = FULL;
                end else if (retire) begin
                    state_nxt = EMPTY;
                end
            end
            FULL: begin
                if (retire) begin
                    load_main_skid = 1'b1;
                    state_nxt      = ONE;
                end
            end
            default: state_nxt = EMPTY;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            main_q <= '0;
            skid_q <= '0;
        end else begin
            if (load_main_in)        main_q <= cap;
            else if (load_main_skid) main_q <= skid_q;
            if (load_skid)           skid_q <= cap;
        end
    end

    assign out_result = main_q.result;
    assign out_flags  = main_q.flags;
    assign out_denorm = main_q.denorm;
    assign out_tag    = main_q.tag;

    // Flags accrue only when an entry actually leaves; a write or clear still
    // keeps whatever retires in the same cycle.
    assign retire_flags = retire ? main_q.flags : 5'b0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)           fflags <= 5'b0;
        else if (fflags_wr)  fflags <= fflags_wdata | retire_flags;
        else if (fflags_clr) fflags <= retire_flags;
        else                 fflags <= fflags | retire_flags;
    end

endmodule

// File: tb/tb_fpadd_wb.sv
module tb_fpadd_wb;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, in_ready;
    logic [63:0] in_result;
    logic [4:0]  in_flags;
    logic        in_denorm, in_p;
    logic [4:0]  in_tag;
    logic        out_valid, out_ready;
    logic [63:0] out_result;
    logic [4:0]  out_flags;
    logic        out_denorm;
    logic [4:0]  out_tag;
    logic [4:0]  fflags;
    logic        fflags_wr, fflags_clr;
    logic [4:0]  fflags_wdata;

    always #5 clk = ~clk;

    fpadd_wb #(.TAG_W(5)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_result(in_result), .in_flags(in_flags), .in_denorm(in_denorm),
        .in_p(in_p), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_flags(out_flags), .out_denorm(out_denorm),
        .out_tag(out_tag),
        .fflags(fflags), .fflags_wr(fflags_wr), .fflags_wdata(fflags_wdata),
        .fflags_clr(fflags_clr)
    );

    typedef struct {
        logic [63:0] result;
        logic [4:0]  flags;
        logic        denorm;
        logic [4:0]  tag;
    } exp_t;

    typedef struct {
        logic [63:0] res;
        logic [4:0]  fl;
        logic        dn;
        logic        p;
        logic [4:0]  tag;
        logic [63:0] exp_res;
    } vec_t;

    exp_t        sb[$];
    exp_t        pend;
    logic [4:0]  fexp;
    int          errors = 0;
    int          checks = 0;
    int          n_ret  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic set_in(input logic [63:0] res, input logic [4:0] fl, input logic dn,
                          input logic p, input logic [4:0] tag, input logic [63:0] exp_res);
        in_valid  = 1'b1;
        in_result = res;
        in_flags  = fl;
        in_denorm = dn;
        in_p      = p;
        in_tag    = tag;
        pend.result = exp_res;
        pend.flags  = fl;
        pend.denorm = dn;
        pend.tag    = tag;
    endtask

    // One clock: check handshake against occupancy model, pop/compare on retire,
    // push on accept, then check fflags after the edge.
    task automatic cyc(output logic acc);
        int         occ;
        logic [4:0] r;
        logic [4:0] fnext;
        exp_t       e;
        @(negedge clk);
        occ = sb.size();
        r   = 5'b0;
        chk("in_ready", {63'b0, in_ready}, {63'b0, occ < 2});
        chk("out_valid", {63'b0, out_valid}, {63'b0, occ > 0});
        if (occ > 0 && out_ready) begin
            e = sb.pop_front();
            chk("out_result", out_result, e.result);
            chk("out_flags", {59'b0, out_flags}, {59'b0, e.flags});
            chk("out_denorm", {63'b0, out_denorm}, {63'b0, e.denorm});
            chk("out_tag", {59'b0, out_tag}, {59'b0, e.tag});
            r = e.flags;
            n_ret++;
        end
        if (fflags_wr)       fnext = fflags_wdata | r;
        else if (fflags_clr) fnext = r;
        else                 fnext = fexp | r;
        acc = in_valid && (occ < 2);
        if (acc) sb.push_back(pend);
        @(posedge clk);
        #1;
        fexp = fnext;
        chk("fflags", {59'b0, fflags}, {59'b0, fexp});
    endtask

    task automatic send(input logic [63:0] res, input logic [4:0] fl, input logic dn,
                        input logic p, input logic [4:0] tag, input logic [63:0] exp_res);
        logic acc;
        int   n;
        set_in(res, fl, dn, p, tag, exp_res);
        n = 0;
        acc = 1'b0;
        while (!acc && n < 50) begin
            cyc(acc);
            n++;
        end
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: tag %0d not accepted within 50 cycles", tag);
        end
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        logic acc;
        in_valid = 1'b0;
        for (int i = 0; i < n; i++) cyc(acc);
    endtask

    task automatic chk_reset_vals(input string tagname);
        chk({tagname, "_in_ready"}, {63'b0, in_ready}, 64'd1);
        chk({tagname, "_out_valid"}, {63'b0, out_valid}, 64'd0);
        chk({tagname, "_out_result"}, out_result, 64'd0);
        chk({tagname, "_out_flags"}, {59'b0, out_flags}, 64'd0);
        chk({tagname, "_out_denorm"}, {63'b0, out_denorm}, 64'd0);
        chk({tagname, "_out_tag"}, {59'b0, out_tag}, 64'd0);
        chk({tagname, "_fflags"}, {59'b0, fflags}, 64'd0);
    endtask

    vec_t vecs[6];

    initial begin
        logic        acc;
        int          n0, nacc;
        logic [63:0] rr;
        logic        rp;

        vecs[0] = '{64'h404F_D1EB_851E_B852, 5'b00001, 1'b0, 1'b0, 5'd3,  64'h404F_D1EB_851E_B852};
        vecs[1] = '{64'h0000_0000_427E_8F5C, 5'b00000, 1'b0, 1'b1, 5'd7,  64'hFFFF_FFFF_427E_8F5C};
        vecs[2] = '{64'h1234_5678_9ABC_DEF0, 5'b10000, 1'b1, 1'b1, 5'd31, 64'hFFFF_FFFF_9ABC_DEF0};
        vecs[3] = '{64'hDEAD_BEEF_0000_0001, 5'b00010, 1'b1, 1'b0, 5'd0,  64'hDEAD_BEEF_0000_0001};
        vecs[4] = '{64'hFFFF_FFFF_FFFF_FFFF, 5'b11111, 1'b0, 1'b1, 5'd16, 64'hFFFF_FFFF_FFFF_FFFF};
        vecs[5] = '{64'h8000_0000_0000_0000, 5'b00000, 1'b0, 1'b0, 5'd1,  64'h8000_0000_0000_0000};

        reset = 1'b1;
        in_valid = 1'b0; in_result = '0; in_flags = '0; in_denorm = 1'b0; in_p = 1'b0; in_tag = '0;
        out_ready = 1'b1; fflags_wr = 1'b0; fflags_wdata = '0; fflags_clr = 1'b0;
        fexp = 5'b0;
        #2;
        chk_reset_vals("por");
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Pass-through of a double, then the rest of the table back-to-back.
        send(vecs[0].res, vecs[0].fl, vecs[0].dn, vecs[0].p, vecs[0].tag, vecs[0].exp_res);
        idle(2);
        chk("pass_fflags", {59'b0, fflags}, 64'd1);
        for (int i = 0; i < 6; i++)
            send(vecs[i].res, vecs[i].fl, vecs[i].dn, vecs[i].p, vecs[i].tag, vecs[i].exp_res);
        idle(3);

        // Backpressure: tags 1..4 with the consumer stalled.
        fflags_clr = 1'b1; idle(1); fflags_clr = 1'b0;
        out_ready = 1'b0;
        send(64'h11, 5'b0, 1'b0, 1'b0, 5'd1, 64'h11);
        send(64'h22, 5'b0, 1'b0, 1'b0, 5'd2, 64'h22);
        set_in(64'h33, 5'b0, 1'b0, 1'b0, 5'd3, 64'h33);
        for (int i = 0; i < 3; i++) cyc(acc);
        chk("bp_in_ready_low", {63'b0, in_ready}, 64'd0);
        chk("bp_held_tag", {59'b0, out_tag}, 64'd1);
        out_ready = 1'b1;
        send(64'h33, 5'b0, 1'b0, 1'b0, 5'd3, 64'h33);
        send(64'h44, 5'b0, 1'b0, 1'b0, 5'd4, 64'h44);
        idle(4);
        chk("bp_drained", sb.size(), 64'd0);

        // Sticky flags.
        fflags_clr = 1'b1; idle(1); fflags_clr = 1'b0;
        send(64'h1, 5'b00100, 1'b0, 1'b0, 5'd5, 64'h1);
        send(64'h2, 5'b00010, 1'b0, 1'b0, 5'd6, 64'h2);
        idle(2);
        chk("sticky_or", {59'b0, fflags}, 64'b00110);
        out_ready = 1'b0;
        send(64'h3, 5'b10000, 1'b0, 1'b0, 5'd8, 64'h3);
        out_ready = 1'b1; fflags_clr = 1'b1;
        idle(1);
        fflags_clr = 1'b0;
        chk("clr_with_retire", {59'b0, fflags}, 64'b10000);
        out_ready = 1'b0;
        fflags_wr = 1'b1; fflags_wdata = 5'b00001; fflags_clr = 1'b1;
        idle(1);
        fflags_wr = 1'b0; fflags_clr = 1'b0; out_ready = 1'b1;
        chk("wr_over_clr", {59'b0, fflags}, 64'b00001);

        // Reset in the middle of a stalled transfer.
        out_ready = 1'b0;
        send(64'hAA, 5'b01000, 1'b1, 1'b0, 5'd9, 64'hAA);
        send(64'hBB, 5'b01000, 1'b1, 1'b0, 5'd10, 64'hBB);
        #2 reset = 1'b1;
        #1;
        chk_reset_vals("arst");
        reset = 1'b0;
        sb.delete();
        fexp = 5'b0;
        out_ready = 1'b1;
        idle(2);

        // Full throughput: 100 back-to-back with the consumer always ready.
        n0 = n_ret;
        nacc = 0;
        for (int i = 0; i < 100; i++) begin
            rr = {$urandom, $urandom};
            rp = 1'($urandom_range(0, 1));
            set_in(rr, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), rp, 5'(i),
                   rp ? {32'hFFFF_FFFF, rr[31:0]} : rr);
            cyc(acc);
            if (acc) nacc++;
        end
        idle(1);
        chk("thru_accepts", nacc, 64'd100);
        chk("thru_retires", n_ret - n0, 64'd100);
        idle(2);
        chk("final_empty", sb.size(), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fpadd_wb.md
# fpadd_wb

Registered writeback stage directly downstream of the combinational `fpadd` datapath. It captures each adder result, its exception flags and its denormal indication behind a valid/ready handshake with a 2-entry skid buffer, so the adder can be driven at full throughput while the consumer (register file / result bus) applies backpressure. It NaN-boxes single-precision results and maintains a sticky 5-bit accrued-exception register (`fflags`) that software can read, write or clear.

## Interface
- `TAG_W`, default 5: width of the destination tag carried alongside each result.
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  `fpadd` output is valid this cycle.
- `in_ready`  out  1  stage can accept an input this cycle.
- `in_result`  in  64  `AS_Result` from `fpadd`.
- `in_flags`  in  5  `Flags` from `fpadd`: [4]=invalid, [3]=div-by-zero, [2]=overflow, [1]=underflow, [0]=inexact.
- `in_denorm`  in  1  `Denorm` from `fpadd`.
- `in_p`  in  1  precision of the operation (1 = single, result in [31:0]).
- `in_tag`  in  TAG_W  destination tag.
- `out_valid`  out  1  result available.
- `out_ready`  in  1  consumer accepts the result.
- `out_result`  out  64  result; upper 32 bits forced to 32'hFFFFFFFF when the entry's `in_p` was 1.
- `out_flags`  out  5  flags of the presented result.
- `out_denorm`  out  1  denormal indication of the presented result.
- `out_tag`  out  TAG_W  tag of the presented result.
- `fflags`  out  5  sticky accrued exception flags.
- `fflags_wr`  in  1  load `fflags` from `fflags_wdata`.
- `fflags_wdata`  in  5  write data for `fflags`.
- `fflags_clr`  in  1  clear `fflags`.

## Operation
- Storage: main register (drives outputs) + one skid register; each entry holds {result, flags, denorm, tag}. NaN-boxing is applied at capture.
- Accept = `in_valid && in_ready`; retire = `out_valid && out_ready`.
- States by occupancy: EMPTY (0 entries), ONE (main valid), FULL (main + skid valid).
  - EMPTY: accept -> ONE.
  - ONE: accept without retire -> FULL (new entry into skid); accept with retire -> ONE (new entry into main); retire only -> EMPTY.
  - FULL: retire -> ONE (skid moves to main). No accept is possible in FULL.
- `in_ready` = 1 in EMPTY and ONE, 0 in FULL; it is a registered function of state and does not depend combinationally on `out_ready`.
- `out_valid` = 1 in ONE and FULL. Output fields are stable while `out_valid && !out_ready`.
- Ordering is strictly FIFO; no entry is ever dropped or duplicated.
- `fflags` next value, in priority order:
  - `fflags_wr`: `fflags_wdata | R`;
  - else `fflags_clr`: `R`;
  - else: `fflags | R`;
  - where `R` = `out_flags` if retire this cycle, else 0. Flags accrue on retire only, never on accept.

## Timing
- Reset (asynchronous assert): state EMPTY, `out_valid`=0, `in_ready`=1, `out_result`=0, `out_flags`=0, `out_denorm`=0, `out_tag`=0, `fflags`=0. Reset asserted mid-transfer discards all held entries.
- Latency: an accept in cycle N gives `out_valid` in cycle N+1 when the stage was EMPTY, or when it was ONE with a retire in N.
- Throughput: 1 result/cycle while `out_ready`=1.
- After backpressure (`out_ready`=0) starts, at most one further input is accepted before `in_ready` drops. `in_ready` returns high the cycle after the first retire out of FULL.
- `fflags` reflects a retired entry's flags in the cycle after the retire.

## Test plan
- Reset: assert `reset` asynchronously between clock edges -> all outputs take their reset values immediately; `in_ready`=1.
- Pass-through, double: `in_result`=64'h404FD1EB851EB852, `in_flags`=5'b00001, `in_p`=0, `in_tag`=3, `out_ready`=1 -> next cycle `out_valid`=1 with identical result, flags 00001 and tag 3; `fflags`=00001 one cycle later.
- NaN-box, single: `in_result`=64'h0000_0000_427E_8F5C, `in_p`=1 -> `out_result`=64'hFFFF_FFFF_427E_8F5C.
- Backpressure: stream tags 1,2,3,4 back-to-back with `out_ready`=0 -> tags 1 and 2 accepted, `in_ready`=0 from the cycle after tag 2 is accepted; then raise `out_ready` -> outputs 1,2,3,4 in order with none lost.
- Sticky flags: retire flags 00100 and then 00010 -> `fflags`=00110. Pulse `fflags_clr` in the same cycle that a 10000 entry retires -> `fflags`=10000. Assert `fflags_wr` (wdata=00001) and `fflags_clr` together with no retire -> `fflags`=00001.
- Full throughput: 100 back-to-back inputs with `out_ready`=1 -> 100 outputs on consecutive cycles and `in_ready` never low.
